axi_burst_reader: RTL and testbench

- AXI4 read master directly upstream of the DDR weight/feature loader.
- Accepts a level-held read command (start, base address, burst count) from the loader and issues fixed 16-beat INCR bursts of DATA_WIDTH-bit beats on the AR channel.
- Forwards R-channel data beat-for-beat onto an AXI-Stream master port with no reordering.
- Raises done once every requested beat has been delivered downstream.

---
 rtl/axi_burst_reader.sv | 182 ++++++++++++++++++
 tb/tb_axi_burst_reader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_reader.sv
// AXI4 read master: splits a level-held read command into aligned fixed-length
// INCR bursts and forwards the returned beats unchanged onto an AXI-Stream port.
module axi_burst_reader #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [24:0]           nburst,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int OFF_W       = $clog2(BURST_BYTES);
    localparam int BEAT_W      = $clog2(BURST_LEN);
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);
    localparam logic [OUT_W-1:0]      MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]      OUT_ONE   = OUT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [24:0]           REM_ONE   = 25'd1;

    localparam logic [1:0] IDLE_ST = 2'd0;
    localparam logic [1:0] READ_ST = 2'd1;
    localparam logic [1:0] END_ST  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic [24:0]           ar_rem_q, ar_rem_d;
    logic [24:0]           r_rem_q, r_rem_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic in_read;
    logic ar_hs;
    logic r_xfer;
    logic last_beat;
    logic burst_done;
    logic unused_addr_low;

    assign unused_addr_low = ^addr[OFF_W-1:0];

    assign in_read    = (state_q == READ_ST);
    assign ar_hs      = arvalid_q && m_axi_arready;
    assign r_xfer     = in_read && m_axi_rvalid && m_axis_tready;
    assign last_beat  = (beat_q == BEAT_LAST);
    assign burst_done = r_xfer && last_beat;

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        ar_rem_d  = ar_rem_q;
        r_rem_d   = r_rem_q;
        out_d     = out_q;
        beat_d    = beat_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            IDLE_ST: begin
                done_d    = 1'b0;
                arvalid_d = 1'b0;
                if (start) begin
                    araddr_d = {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    ar_rem_d = nburst;
                    r_rem_d  = nburst;
                    out_d    = '0;
                    beat_d   = '0;
                    err_d    = 1'b0;
                    state_d  = (nburst == '0) ? END_ST : READ_ST;
                end
            end

            READ_ST: begin
                if (ar_hs) begin
                    araddr_d = araddr_q + ADDR_STEP;
                    ar_rem_d = ar_rem_q - REM_ONE;
                end
                if (r_xfer) begin
                    beat_d = last_beat ? '0 : beat_q + BEAT_ONE;
                    if ((m_axi_rlast != last_beat) || (m_axi_rresp != 2'b00)) begin
                        err_d = 1'b1;
                    end
                end
                if (burst_done) begin
                    r_rem_d = r_rem_q - REM_ONE;
                end
                case ({ar_hs, burst_done})
                    2'b10:   out_d = out_q + OUT_ONE;
                    2'b01:   out_d = out_q - OUT_ONE;
                    default: out_d = out_q;
                endcase
                // A pending request is not yet in out_q, so the limit is
                // checked only when a new request would be raised.
                if (!arvalid_q || ar_hs) begin
                    arvalid_d = (ar_rem_d != '0) && (out_d < MAX_OUT);
                end
                if ((r_rem_q == '0) && (ar_rem_q == '0)) begin
                    arvalid_d = 1'b0;
                    state_d   = END_ST;
                end
            end

            END_ST: begin
                arvalid_d = 1'b0;
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE_ST;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                arvalid_d = 1'b0;
                done_d    = 1'b0;
                state_d   = IDLE_ST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE_ST;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            ar_rem_q  <= '0;
            r_rem_q   <= '0;
            out_q     <= '0;
            beat_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            ar_rem_q  <= ar_rem_d;
            r_rem_q   <= r_rem_d;
            out_q     <= out_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = in_read && m_axis_tready;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tvalid = in_read && m_axi_rvalid;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: behavioural AXI slave, scoreboard queues for
// AR addresses and stream beats, and directed command scenarios.
module tb_axi_burst_reader;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int BL = 16;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] addr;
    logic [24:0]   nburst;
    logic          done;
    logic          err;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;

    axi_burst_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .nburst(nburst),
        .done(done), .err(err),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
        logic [31:0] x;
        x = a + 32'(b * 8);
        return {x, ~x};
    endfunction

    logic [63:0] exp_q[$];
    logic [31:0] exp_ar[$];

    // slave knobs and state
    int lat = 2, gap_pct = 0, ar_rand = 0;
    int err_burst = -1, err_beat = 0, early_burst = -1;
    logic [31:0] s_addr[$];
    int s_time[$];
    int s_beat = 0, s_burst = 0;
    logic s_ar_hs, s_r_hs, s_rst;
    logic [31:0] s_a;

    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        forever begin
            @(negedge clk);
            s_ar_hs = arvalid && arready;
            s_r_hs  = rvalid && rready;
            s_rst   = rst;
            s_a     = araddr;
            @(posedge clk);
            #1;
            if (s_rst) begin
                s_addr.delete(); s_time.delete();
                s_beat = 0; s_burst = 0;
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; arready = 1'b0;
            end else begin
                if (s_ar_hs) begin
                    s_addr.push_back(s_a);
                    s_time.push_back(cyc + lat);
                end
                if (s_r_hs) begin
                    s_beat++;
                    if (s_beat == BL) begin
                        s_beat = 0;
                        s_burst++;
                        void'(s_addr.pop_front());
                        void'(s_time.pop_front());
                    end
                end
                arready = (ar_rand == 0) || ($urandom_range(0, 1) == 1);
                if (!(rvalid && !s_r_hs)) begin
                    if (s_addr.size() > 0 && cyc >= s_time[0] && $urandom_range(0, 99) >= gap_pct) begin
                        rvalid = 1'b1;
                        rdata  = beat_data(s_addr[0], s_beat);
                        rlast  = (s_burst == early_burst) ? (s_beat == BL - 2) : (s_beat == BL - 1);
                        rresp  = (s_burst == err_burst && s_beat == err_beat) ? 2'b10 : 2'b00;
                    end else begin
                        rvalid = 1'b0;
                        rlast  = 1'b0;
                        rresp  = 2'b00;
                    end
                end
            end
        end
    end

    // monitor state
    int beats = 0, mon_beat = 0, last_beat_cyc = -1;
    int out_cnt = 0, max_out = 0, ar_viol = 0, ar_cnt = 0, stab_viol = 0;
    int first_ar_cyc = -1, ar_cnt_at_first_r = -1, first_last_cyc = -1, fifth_ar_cyc = -1;
    int win = 0, win_beats = 0, rr_mis = 0;
    logic pav = 1'b0, par = 1'b0;
    logic [31:0] paddr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                out_cnt = 0; mon_beat = 0; pav = 1'b0; par = 1'b0;
            end else begin
                if (pav && !par && (!arvalid || araddr != paddr)) stab_viol++;
                if (arvalid && out_cnt >= MO) ar_viol++;
                if (arvalid && first_ar_cyc < 0) first_ar_cyc = cyc;
                if (arvalid && arready) begin
                    ar_cnt++;
                    if (ar_cnt == 5) fifth_ar_cyc = cyc;
                    if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
                    else check("araddr", longint'(araddr), longint'(exp_ar.pop_front()));
                    check("arlen", longint'(arlen), 15);
                    check("arsize", longint'(arsize), 3);
                    check("arburst", longint'(arburst), 1);
                end
                pav = arvalid; par = arready; paddr = araddr;
                if (win != 0 && first_ar_cyc >= 0 && beats < win_beats && rready != tready) rr_mis++;
                if (tvalid && tready) begin
                    if (beats == 0) ar_cnt_at_first_r = ar_cnt;
                    beats++;
                    last_beat_cyc = cyc;
                    if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
                    else check("tdata", longint'(tdata), longint'(exp_q.pop_front()));
                    mon_beat++;
                    if (mon_beat == BL) begin
                        mon_beat = 0;
                        out_cnt--;
                        if (first_last_cyc < 0) first_last_cyc = cyc;
                    end
                end
                if (arvalid && arready) out_cnt++;
                if (out_cnt > max_out) max_out = out_cnt;
            end
        end
    end

    int tog = 0;
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = (tog != 0) ? ~tready : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int start_cyc = 0;

    task automatic issue(input logic [31:0] a, input int nb, input logic [31:0] base);
        for (int k = 0; k < nb; k++) begin
            exp_ar.push_back(base + 32'(k * 128));
            for (int b = 0; b < BL; b++) exp_q.push_back(beat_data(base + 32'(k * 128), b));
        end
        beats = 0; ar_cnt = 0; first_ar_cyc = -1; first_last_cyc = -1; fifth_ar_cyc = -1;
        max_out = 0; ar_viol = 0; stab_viol = 0; ar_cnt_at_first_r = -1; rr_mis = 0;
        @(posedge clk);
        #1;
        addr = a; nburst = 25'(nb); start = 1'b1; start_cyc = cyc;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic finish_cmd(input string tag, input logic exp_err, input bit had_beats);
        int dc;
        int d;
        wait_done(4000, dc);
        d = dc - last_beat_cyc;
        if (had_beats) check({tag, "_done_after_last"}, longint'(d >= 1 && d <= 3), 1);
        check({tag, "_err"}, longint'(err), longint'(exp_err));
        check({tag, "_beats_left"}, exp_q.size(), 0);
        check({tag, "_ars_left"}, exp_ar.size(), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_hold"}, longint'(done), 1);
        @(negedge clk);
        check({tag, "_done_drop"}, longint'(done), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; addr = '0; nburst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", longint'(arvalid), 0);
        check("rst_araddr", longint'(araddr), 0);
        check("rst_done", longint'(done), 0);
        check("rst_err", longint'(err), 0);
        check("rst_rready", longint'(rready), 0);
        check("rst_tvalid", longint'(tvalid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // alignment and three-burst chain
        issue(32'h1000_0040, 3, 32'h1000_0000);
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("t1_first_ar_lat", first_ar_cyc - start_cyc, 2);
        finish_cmd("t1", 1'b0, 1'b1);
        check("t1_beats", beats, 48);

        // empty command
        issue(32'h4000_0000, 0, 32'h4000_0000);
        @(negedge clk);
        @(negedge clk);
        check("t4_done_early", longint'(done), 0);
        @(negedge clk);
        check("t4_done_at_2", longint'(done), 1);
        finish_cmd("t4", 1'b0, 1'b0);
        check("t4_no_ar", ar_cnt, 0);
        check("t4_no_arvalid", first_ar_cyc, -1);

        // outstanding limit with long read latency
        lat = 50;
        issue(32'h0000_0000, 10, 32'h0000_0000);
        finish_cmd("t2", 1'b0, 1'b1);
        check("t2_ars_before_data", ar_cnt_at_first_r, 4);
        check("t2_max_out", max_out, 4);
        check("t2_limit_viol", ar_viol, 0);
        check("t2_fifth_ar_follow",
              longint'(fifth_ar_cyc - first_last_cyc >= 0 && fifth_ar_cyc - first_last_cyc <= 1), 1);
        lat = 2;

        // backpressure, rvalid gaps, random arready
        lat = 3; gap_pct = 30; ar_rand = 1; tog = 1; win = 1; win_beats = 32;
        issue(32'h2000_0000, 2, 32'h2000_0000);
        finish_cmd("t3", 1'b0, 1'b1);
        check("t3_rready_mirror", rr_mis, 0);
        check("t3_ar_stable", stab_viol, 0);
        check("t3_beats", beats, 32);
        lat = 2; gap_pct = 0; ar_rand = 0; tog = 0; win = 0;

        // SLVERR on beat 5 of burst 0
        err_burst = s_burst; err_beat = 5;
        issue(32'h5000_0000, 2, 32'h5000_0000);
        finish_cmd("t5a", 1'b1, 1'b1);
        err_burst = -1;

        // rlast on beat 14; err must clear on the new command first
        early_burst = s_burst;
        issue(32'h6000_0000, 1, 32'h6000_0000);
        @(posedge clk);
        @(negedge clk);
        check("t5b_err_cleared", longint'(err), 0);
        finish_cmd("t5b", 1'b1, 1'b1);
        early_burst = -1;

        issue(32'h7000_0000, 1, 32'h7000_0000);
        finish_cmd("t5c", 1'b0, 1'b1);

        // reset in the middle of a 64-beat read
        issue(32'h8000_0000, 4, 32'h8000_0000);
        for (int i = 0; i < 2000 && beats < 20; i++) @(negedge clk);
        check("t6_reached_20", longint'(beats >= 20), 1);
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_ar.delete();
        @(negedge clk);
        check("t6_arvalid", longint'(arvalid), 0);
        check("t6_araddr", longint'(araddr), 0);
        check("t6_done", longint'(done), 0);
        check("t6_err", longint'(err), 0);
        check("t6_rready", longint'(rready), 0);
        check("t6_tvalid", longint'(tvalid), 0);
        issue(32'h9000_0000, 1, 32'h9000_0000);
        finish_cmd("t6_after", 1'b0, 1'b1);
        check("t6_after_beats", beats, 16);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
